// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator for decode.
// Output register plus one skid entry; saturating illegal counter.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_value,
  output logic [2:0]       imm_fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef logic [XLEN-1:0] xword_t;

  typedef struct packed {
    xword_t     imm;
    logic [2:0] fmt;
    logic       ill;
  } res_t;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;
  localparam bit         RV64    = (XLEN == 64);

  logic [6:0] op;
  logic [2:0] f3;
  logic       sh_f3;
  logic       op_imm;
  logic       op_imm32;
  logic       op_i;
  logic       op_sh;
  logic       sh_bad;
  logic       op_s;
  logic       op_b;
  logic       op_u;
  logic       op_j;
  logic       op_r;
  xword_t     shamt;

  assign op       = instruction[6:0];
  assign f3       = instruction[14:12];
  assign sh_f3    = (f3 == 3'b001) || (f3 == 3'b101);
  assign op_imm   = (op == 7'b0010011);
  assign op_imm32 = RV64 && (op == 7'b0011011);
  assign op_i     = (op == 7'b0000011) || (op == 7'b1100111)
                 || ((op_imm || op_imm32) && !sh_f3);
  assign op_sh    = (op_imm || op_imm32) && sh_f3;
  assign sh_bad   = instruction[25] && (!RV64 || op_imm32);
  assign op_s     = (op == 7'b0100011);
  assign op_b     = (op == 7'b1100011);
  assign op_u     = (op == 7'b0110111) || (op == 7'b0010111);
  assign op_j     = (op == 7'b1101111);
  assign op_r     = (op == 7'b0110011) || (RV64 && (op == 7'b0111011));

  // 6-bit shamt only for the native-width RV64 shift
  assign shamt = (RV64 && op_imm) ? xword_t'(instruction[25:20])
                                  : xword_t'(instruction[24:20]);

  res_t dec;

  always_comb begin
    dec = '{imm: '0, fmt: FMT_ILL, ill: 1'b1};
    unique case (1'b1)
      op_i: dec = '{xword_t'($signed(instruction[31:20])), FMT_I, 1'b0};
      op_sh: begin
        if (!sh_bad) dec = '{shamt, FMT_I, 1'b0};
      end
      op_s: dec = '{xword_t'($signed({instruction[31:25],
                                      instruction[11:7]})),
                    FMT_S, 1'b0};
      op_b: dec = '{xword_t'($signed({instruction[31], instruction[7],
                                      instruction[30:25],
                                      instruction[11:8], 1'b0})),
                    FMT_B, 1'b0};
      op_u: dec = '{xword_t'($signed({instruction[31:12], 12'b0})),
                    FMT_U, 1'b0};
      op_j: dec = '{xword_t'($signed({instruction[31],
                                      instruction[19:12],
                                      instruction[20],
                                      instruction[30:21], 1'b0})),
                    FMT_J, 1'b0};
      op_r: dec = '{'0, FMT_R, 1'b0};
      default: ;
    endcase
  end

  res_t       out_q;
  res_t       out_n;
  res_t       skid_q;
  res_t       skid_n;
  logic       out_vld_n;
  logic       skid_full;
  logic       skid_full_n;
  logic       acc;
  logic       cons;

  assign acc  = in_valid && in_ready;
  assign cons = out_valid && out_ready;

  always_comb begin
    out_n       = out_q;
    skid_n      = skid_q;
    out_vld_n   = out_valid;
    skid_full_n = skid_full;
    if (!out_valid || cons) begin
      if (skid_full) begin
        out_n       = skid_q;
        out_vld_n   = 1'b1;
        skid_full_n = acc;
        if (acc) skid_n = dec;
      end else if (acc) begin
        out_n     = dec;
        out_vld_n = 1'b1;
      end else begin
        out_vld_n = 1'b0;
      end
    end else if (acc) begin
      skid_n      = dec;
      skid_full_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q         <= '0;
      skid_q        <= '0;
      out_valid     <= 1'b0;
      skid_full     <= 1'b0;
      in_ready      <= 1'b0;
      illegal_count <= '0;
    end else begin
      out_q     <= out_n;
      skid_q    <= skid_n;
      out_valid <= out_vld_n;
      skid_full <= skid_full_n;
      in_ready  <= !skid_full_n;
      if (acc && dec.ill && !(&illegal_count))
        illegal_count <= illegal_count + 1'b1;
    end
  end

  assign imm_value = out_q.imm;
  assign imm_fmt   = out_q.fmt;
  assign illegal   = out_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: RV64, RV32 and a 2-bit-counter instance
// share stimulus and are checked against a queue-based reference.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instruction;

  logic        ir64, ov64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;
  logic        ir32, ov32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [15:0] cnt32;
  logic        irs, ovs, ills;
  logic [63:0] imms;
  logic [2:0]  fmts;
  logic [1:0]  cnts;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  bit          armed;
  int          c64, c32, cs;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64),
    .instruction(instruction), .out_valid(ov64), .out_ready(out_ready),
    .imm_value(imm64), .imm_fmt(fmt64), .illegal(ill64),
    .illegal_count(cnt64));

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
    .instruction(instruction), .out_valid(ov32), .out_ready(out_ready),
    .imm_value(imm32), .imm_fmt(fmt32), .illegal(ill32),
    .illegal_count(cnt32));

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) duts (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irs),
    .instruction(instruction), .out_valid(ovs), .out_ready(out_ready),
    .imm_value(imms), .imm_fmt(fmts), .illegal(ills),
    .illegal_count(cnts));

  function automatic void ref_dec(input int xlen, input logic [31:0] i,
                                  output logic [63:0] imm,
                                  output logic [2:0] fmt,
                                  output logic ill);
    bit rv64 = (xlen == 64);
    bit sh = (i[14:12] == 3'd1) || (i[14:12] == 3'd5);
    imm = 64'd0;
    fmt = 3'd7;
    ill = 1'b1;
    case (i[6:0])
      7'h03, 7'h67: begin
        imm = 64'($signed(i[31:20])); fmt = 3'd1; ill = 1'b0;
      end
      7'h13, 7'h1B: begin
        if (i[6:0] == 7'h1B && !rv64) begin
          ill = 1'b1;
        end else if (!sh) begin
          imm = 64'($signed(i[31:20])); fmt = 3'd1; ill = 1'b0;
        end else if (rv64 && i[6:0] == 7'h13) begin
          imm = 64'(i[25:20]); fmt = 3'd1; ill = 1'b0;
        end else if (!i[25]) begin
          imm = 64'(i[24:20]); fmt = 3'd1; ill = 1'b0;
        end
      end
      7'h23: begin
        imm = 64'($signed({i[31:25], i[11:7]})); fmt = 3'd2; ill = 1'b0;
      end
      7'h63: begin
        imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        fmt = 3'd3; ill = 1'b0;
      end
      7'h37, 7'h17: begin
        imm = 64'($signed({i[31:12], 12'd0})); fmt = 3'd4; ill = 1'b0;
      end
      7'h6F: begin
        imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        fmt = 3'd5; ill = 1'b0;
      end
      7'h33: begin fmt = 3'd0; ill = 1'b0; end
      7'h3B: if (rv64) begin fmt = 3'd0; ill = 1'b0; end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom();
    logic [6:0] ops [14] = '{7'h03, 7'h67, 7'h13, 7'h13, 7'h1B, 7'h23,
                             7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B,
                             7'h7F, 7'h0F};
    r[6:0] = ops[$urandom_range(0, 13)];
    if ($urandom_range(0, 9) == 0) r[6:0] = 7'($urandom());
    return r;
  endfunction

  task automatic step();
    bit acc = in_valid && armed && (q.size() < 2);
    bit cons = (q.size() > 0) && out_ready;
    logic [63:0] e;
    logic [2:0] f;
    logic il;
    @(posedge clk);
    #1;
    if (cons) void'(q.pop_front());
    if (acc) begin
      q.push_back(instruction);
      ref_dec(64, instruction, e, f, il);
      if (il) begin c64++; if (cs < 3) cs++; end
      ref_dec(32, instruction, e, f, il);
      if (il) c32++;
    end
    armed = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    q.delete();
    armed = 1'b0;
    c64 = 0; c32 = 0; cs = 0;
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction = 32'd0;
    armed = 1'b0; c64 = 0; c32 = 0; cs = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ov64, ir64, ill64, fmt64, imm64, cnt64} !== '0) begin
      errors++;
      $display("FAIL reset64 got ov=%b ir=%b ill=%b fmt=%0d imm=%h cnt=%0d exp 0",
               ov64, ir64, ill64, fmt64, imm64, cnt64);
    end
    checks++;
    if ({ov32, ir32, ovs, irs, cnts} !== '0) begin
      errors++;
      $display("FAIL reset_other got %b exp 0",
               {ov32, ir32, ovs, irs, cnts});
    end
    #3 rst_n = 1'b1;
    step();
    checks++;
    if (ir64 !== 1'b1 || ov64 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ir=%b ov=%b exp ir=1 ov=0",
               ir64, ov64);
    end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    in_valid = 1'b1;
    instruction = 32'hFFF00093;
    step();
    in_valid = 1'b0;
    checks++;
    if (ov64 !== 1'b1 || imm64 !== 64'hFFFFFFFFFFFFFFFF ||
        fmt64 !== 3'd1 || ill64 !== 1'b0) begin
      errors++;
      $display("FAIL addi got ov=%b imm=%h fmt=%0d ill=%b exp 1 ffffffffffffffff 1 0",
               ov64, imm64, fmt64, ill64);
    end
    step();
    checks++;
    if (ov64 !== 1'b0) begin
      errors++;
      $display("FAIL addi_drain got ov=%b exp 0", ov64);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [3] = '{32'h0020A423, 32'hFE000EE3, 32'h123452B7};
    logic [63:0] exp_imm [3] = '{64'h8, 64'hFFFFFFFFFFFFFFFC, 64'h12345000};
    logic [2:0]  exp_fmt [3] = '{3'd2, 3'd3, 3'd4};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      instruction = ins[k];
      step();
      checks++;
      if (ov64 !== 1'b1 || imm64 !== exp_imm[k] ||
          fmt64 !== exp_fmt[k] || ill64 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_%0d got ov=%b imm=%h fmt=%0d exp imm=%h fmt=%0d",
                 k, ov64, imm64, fmt64, exp_imm[k], exp_fmt[k]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (ov64 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got ov=%b exp 0", ov64);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction = 32'h0020A423;
    step();
    checks++;
    if (ov64 !== 1'b1 || ir64 !== 1'b1 || imm64 !== 64'h8) begin
      errors++;
      $display("FAIL bp_first got ov=%b ir=%b imm=%h exp 1 1 8",
               ov64, ir64, imm64);
    end
    instruction = 32'hFE000EE3;
    step();
    instruction = 32'h123452B7;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir64 !== 1'b0 || ov64 !== 1'b1 || imm64 !== 64'h8 ||
          fmt64 !== 3'd2) begin
        errors++;
        $display("FAIL bp_hold_%0d got ir=%b ov=%b imm=%h fmt=%0d exp 0 1 8 2",
                 k, ir64, ov64, imm64, fmt64);
      end
      step();
    end
    out_ready = 1'b1;
    checks++;
    if (ir64 !== 1'b0 || imm64 !== 64'h8) begin
      errors++;
      $display("FAIL bp_pre got ir=%b imm=%h exp 0 8", ir64, imm64);
    end
    step();
    checks++;
    if (ir64 !== 1'b1 || ov64 !== 1'b1 || imm64 !== 64'hFFFFFFFFFFFFFFFC ||
        fmt64 !== 3'd3) begin
      errors++;
      $display("FAIL bp_second got ir=%b ov=%b imm=%h fmt=%0d exp 1 1 fffffffffffffffc 3",
               ir64, ov64, imm64, fmt64);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (ov64 !== 1'b1 || imm64 !== 64'h12345000 || fmt64 !== 3'd4) begin
      errors++;
      $display("FAIL bp_third got ov=%b imm=%h fmt=%0d exp 1 12345000 4",
               ov64, imm64, fmt64);
    end
    step();
    checks++;
    if (ov64 !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got ov=%b exp 0 (duplicate)", ov64);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    instruction = 32'hFFFFFFFF;
    step();
    instruction = 32'h02009093;
    checks++;
    if (fmt64 !== 3'd7 || imm64 !== 64'd0 || ill64 !== 1'b1 ||
        cnt64 !== 16'd1 || cnt32 !== 16'd1) begin
      errors++;
      $display("FAIL ill_ones got fmt=%0d imm=%h ill=%b cnt64=%0d cnt32=%0d exp 7 0 1 1 1",
               fmt64, imm64, ill64, cnt64, cnt32);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (ill32 !== 1'b1 || fmt32 !== 3'd7 || imm32 !== 32'd0 ||
        cnt32 !== 16'd2) begin
      errors++;
      $display("FAIL slli_rv32 got ill=%b fmt=%0d imm=%h cnt=%0d exp 1 7 0 2",
               ill32, fmt32, imm32, cnt32);
    end
    checks++;
    if (ill64 !== 1'b0 || fmt64 !== 3'd1 || imm64 !== 64'h20 ||
        cnt64 !== 16'd1) begin
      errors++;
      $display("FAIL slli_rv64 got ill=%b fmt=%0d imm=%h cnt=%0d exp 0 1 20 1",
               ill64, fmt64, imm64, cnt64);
    end
    step();
  endtask

  task automatic test_saturation();
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    instruction = 32'hFFFFFFFF;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (cnts !== 2'((k > 3) ? 3 : k) || cnt64 !== 16'(k)) begin
        errors++;
        $display("FAIL sat_%0d got cnt2=%0d cnt64=%0d exp %0d %0d",
                 k, cnts, cnt64, (k > 3) ? 3 : k, k);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    checks++;
    if (cnts !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold got %0d exp 3", cnts);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [63:0] e;
    logic [2:0] f;
    logic il;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instruction = rnd_instr();
      step();
      checks++;
      if (ov64 !== (q.size() > 0) || ir64 !== (q.size() < 2) ||
          ov32 !== ov64 || ovs !== ov64) begin
        errors++;
        $display("FAIL rnd_hs n=%0d got ov=%b ir=%b exp ov=%b ir=%b",
                 n, ov64, ir64, q.size() > 0, q.size() < 2);
      end
      checks++;
      if (cnt64 !== 16'(c64) || cnt32 !== 16'(c32) || cnts !== 2'(cs)) begin
        errors++;
        $display("FAIL rnd_cnt n=%0d got %0d %0d %0d exp %0d %0d %0d",
                 n, cnt64, cnt32, cnts, c64, c32, cs);
      end
      if (q.size() > 0) begin
        ref_dec(64, q[0], e, f, il);
        checks++;
        if (imm64 !== e || fmt64 !== f || ill64 !== il || imms !== e) begin
          errors++;
          $display("FAIL rnd_rv64 n=%0d ins=%h got %h/%0d/%b exp %h/%0d/%b",
                   n, q[0], imm64, fmt64, ill64, e, f, il);
        end
        ref_dec(32, q[0], e, f, il);
        checks++;
        if (imm32 !== e[31:0] || fmt32 !== f || ill32 !== il) begin
          errors++;
          $display("FAIL rnd_rv32 n=%0d ins=%h got %h/%0d/%b exp %h/%0d/%b",
                   n, q[0], imm32, fmt32, ill32, e[31:0], f, il);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction = 32'hFFFFFFFF;
    step();
    instruction = 32'hFFF00093;
    step();
    in_valid = 1'b0;
    checks++;
    if (ir64 !== 1'b0 || cnt64 !== 16'd1) begin
      errors++;
      $display("FAIL mid_fill got ir=%b cnt=%0d exp 0 1", ir64, cnt64);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ov64 !== 1'b0 || cnt64 !== 16'd0 || ir64 !== 1'b0 ||
        ov32 !== 1'b0 || cnts !== 2'd0) begin
      errors++;
      $display("FAIL mid_async got ov=%b cnt=%0d ir=%b exp 0 0 0",
               ov64, cnt64, ir64);
    end
    q.delete();
    armed = 1'b0;
    c64 = 0; c32 = 0; cs = 0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    checks++;
    if (ir64 !== 1'b1 || ov64 !== 1'b0) begin
      errors++;
      $display("FAIL mid_release got ir=%b ov=%b exp 1 0", ir64, ov64);
    end
    in_valid = 1'b1;
    instruction = 32'h0020A423;
    step();
    in_valid = 1'b0;
    checks++;
    if (ov64 !== 1'b1 || imm64 !== 64'h8 || fmt64 !== 3'd2 ||
        ill64 !== 1'b0) begin
      errors++;
      $display("FAIL mid_first got ov=%b imm=%h fmt=%0d exp 1 8 2",
               ov64, imm64, fmt64);
    end
    step();
    checks++;
    if (ov64 !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain got ov=%b exp 0 (stale entry)", ov64);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
